// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, default reset PC and fetch FSM state type.
package instr_fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous queue of {pc, instr} entries with single-cycle flush.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !flush;
    assign do_pop = pop && !empty && !flush;
    assign empty = count == '0;
    // Head reads as zero when empty so decode never sees stale entries.
    assign rdata = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch FSM feeding an instruction queue, with
// redirect flush and DRAIN state to discard the response of an abandoned fetch.
module instr_fetch import instr_fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_e state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [CW-1:0] count, count_after;
    logic push, pop, empty;
    logic [ADDR_W+INSTR_W-1:0] head;
    assign push = state == WAIT && imem_rsp_valid && !redirect_valid;
    assign pop = instr_valid && instr_ready && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);
    assign imem_req_valid = state == REQ;
    assign imem_req_addr = pc;
    assign instr_valid = !empty;
    assign {instr_pc, instruction} = head;
    instr_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + INSTR_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .flush(redirect_valid),
        .push(push),
        .pop(pop),
        .wdata({pc, imem_rsp_data}),
        .rdata(head),
        .count(count),
        .empty(empty)
    );
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        if (redirect_valid) begin
            pc_nx = redirect_pc;
            // A fetch still in flight must have its response swallowed first.
            state_nx = ((state == REQ && imem_req_ready) ||
                        ((state == WAIT || state == DRAIN) && !imem_rsp_valid)) ? DRAIN : REQ;
        end else
            case (state)
                IDLE: state_nx = count < CW'(DEPTH) ? REQ : IDLE;
                REQ: state_nx = imem_req_ready ? WAIT : REQ;
                WAIT:
                    if (imem_rsp_valid) begin
                        pc_nx = pc + 32'd4;
                        state_nx = count_after < CW'(DEPTH) ? REQ : IDLE;
                    end
                DRAIN: state_nx = imem_rsp_valid ? REQ : DRAIN;
                default: state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
        end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario tasks with hand-computed expectations.
module tb_instr_fetch;
    logic clk = 0, rst_n = 0;
    logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [31:0] imem_req_addr, imem_rsp_data = 0;
    logic redirect_valid = 0, instr_valid, instr_ready = 0;
    logic [31:0] redirect_pc = 0, instruction, instr_pc;
    int vectors = 0, errors = 0;
    bit auto_mem = 0, pending = 0;
    logic [31:0] pending_addr = 0;
    logic [31:0] acc_q[$], pop_pc_q[$], pop_ins_q[$];

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock; in auto mode the memory answers one cycle after acceptance.
    task automatic step();
        logic acc;
        logic [31:0] a;
        if (auto_mem) begin
            imem_rsp_valid = pending;
            imem_rsp_data = pending ? mem_word(pending_addr) : 32'h0;
        end
        acc = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        if (acc) acc_q.push_back(a);
        if (instr_valid && instr_ready && !redirect_valid) begin
            pop_pc_q.push_back(instr_pc);
            pop_ins_q.push_back(instruction);
        end
        @(posedge clk);
        #1;
        pending = acc;
        pending_addr = a;
    endtask

    task automatic do_reset();
        auto_mem = 0;
        pending = 0;
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        imem_rsp_data = 0;
        redirect_valid = 0;
        instr_ready = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        acc_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
    endtask

    task automatic rsp(input logic [31:0] d);
        imem_rsp_valid = 1;
        imem_rsp_data = d;
        step();
        imem_rsp_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        vectors++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h want 00000000", instruction); end
        vectors++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sequential();
        do_reset();
        auto_mem = 1;
        imem_req_ready = 1;
        instr_ready = 1;
        step();
        step();
        step();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL seq_first_valid: got valid=%b pc=%h want valid=1 pc=00000000", instr_valid, instr_pc); end
        repeat (12) step();
        vectors++; if (acc_q.size() < 3) begin errors++; $display("FAIL seq_req_count: got %0d want >=3", acc_q.size()); end
        else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin errors++; $display("FAIL seq_req_addr: got %h %h %h want 00000000 00000004 00000008", acc_q[0], acc_q[1], acc_q[2]); end
        vectors++; if (pop_pc_q.size() < 3) begin errors++; $display("FAIL seq_pop_count: got %0d want >=3", pop_pc_q.size()); end
        else if (pop_pc_q[0] !== 32'h0 || pop_pc_q[1] !== 32'h4 || pop_pc_q[2] !== 32'h8) begin errors++; $display("FAIL seq_pop_pc: got %h %h %h want 00000000 00000004 00000008", pop_pc_q[0], pop_pc_q[1], pop_pc_q[2]); end
        vectors++; if (pop_ins_q.size() < 3) begin errors++; $display("FAIL seq_pop_ins_count: got %0d want >=3", pop_ins_q.size()); end
        else if (pop_ins_q[0] !== 32'hDEAD_0000 || pop_ins_q[2] !== 32'hDEAD_0008) begin errors++; $display("FAIL seq_pop_ins: got %h %h want dead0000 dead0008", pop_ins_q[0], pop_ins_q[2]); end
    endtask

    task automatic test_full();
        do_reset();
        auto_mem = 1;
        imem_req_ready = 1;
        instr_ready = 0;
        repeat (20) step();
        vectors++; if (acc_q.size() !== 4) begin errors++; $display("FAIL full_req_count: got %0d want 4", acc_q.size()); end
        else if (acc_q[3] !== 32'hC) begin errors++; $display("FAIL full_last_addr: got %h want 0000000c", acc_q[3]); end
        vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_idle: got %b want 0", imem_req_valid); end
        vectors++; if (instr_pc !== 32'h0 || instruction !== 32'hDEAD_0000) begin errors++; $display("FAIL full_head_stable: got pc=%h ins=%h want 00000000 dead0000", instr_pc, instruction); end
        instr_ready = 1;
        step();
        instr_ready = 0;
        vectors++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL full_after_pop: got %h want 00000004", instr_pc); end
        acc_q.delete();
        repeat (6) step();
        vectors++; if (acc_q.size() < 1) begin errors++; $display("FAIL full_refill_count: got %0d want >=1", acc_q.size()); end
        else if (acc_q[0] !== 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h want 00000010", acc_q[0]); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_req_ready = 1;
        step();
        step();
        rsp(32'h1111_0000);
        step();
        vectors++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rw_pre_valid: got %b want 1", instr_valid); end
        redirect_valid = 1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 0;
        vectors++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_flush: got valid=%b req=%b want 0 0", instr_valid, imem_req_valid); end
        step();
        vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drain_hold: got %b want 0", imem_req_valid); end
        rsp(32'h1234);
        vectors++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rw_discard: got valid=%b req=%b addr=%h want 0 1 00000100", instr_valid, imem_req_valid, imem_req_addr); end
        step();
        rsp(32'hAAAA_0100);
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== 32'hAAAA_0100) begin errors++; $display("FAIL rw_new_fetch: got valid=%b pc=%h ins=%h want 1 00000100 aaaa0100", instr_valid, instr_pc, instruction); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        imem_req_ready = 1;
        step();
        step();
        rsp(32'h2222);
        step();
        redirect_valid = 1;
        redirect_pc = 32'h200;
        instr_ready = 1;
        rsp(32'h5555);
        redirect_valid = 0;
        instr_ready = 0;
        vectors++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rr_redirect: got valid=%b req=%b addr=%h want 0 1 00000200", instr_valid, imem_req_valid, imem_req_addr); end
        step();
        rsp(32'h3333);
        vectors++; if (instr_pc !== 32'h200 || instruction !== 32'h3333) begin errors++; $display("FAIL rr_target: got pc=%h ins=%h want 00000200 00003333", instr_pc, instruction); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_first_req: got req=%b addr=%h want 1 00000000", imem_req_valid, imem_req_addr); end
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 0;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect_addr: got req=%b addr=%h want 1 fffffffc", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1;
        step();
        rsp(32'h7777);
        vectors++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); end
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got req=%b addr=%h want 1 00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_req_ready = 1;
        step();
        step();
        rsp(32'hA0);
        step();
        rsp(32'hA4);
        step();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rm_pre: got valid=%b pc=%h want 1 00000000", instr_valid, instr_pc); end
        rst_n = 0;
        #1;
        vectors++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rm_async: got valid=%b req=%b addr=%h pc=%h want 0 0 00000000 00000000", instr_valid, imem_req_valid, imem_req_addr, instr_pc); end
        @(posedge clk);
        #1;
        rst_n = 1;
        rsp(32'h9999);
        vectors++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_restart: got valid=%b req=%b addr=%h want 0 1 00000000", instr_valid, imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
